// File: rtl/itransform_pkg.sv
// itransform_pkg: shared constants and helpers for the 4x4 inverse transform.
// Holds the fixed-point multipliers, datapath widths and rounding constants
// used by both butterfly passes and the reconstruction stage.
package itransform_pkg;

    // Element widths of the packed block interfaces
    localparam int COEFF_W   = 12;
    localparam int PIX_W     = 8;
    localparam int NUM_ELEMS = 16;

    // Internal datapath widths: first-pass result, second-pass sums,
    // multiplier products and the pixel + residual reconstruction sum
    localparam int TMP_W   = 14;
    localparam int SUM_W   = 17;
    localparam int PROD_W  = 32;
    localparam int RECON_W = 18;

    // Q16 transform multipliers (KC1 is 1 + 20091/65536)
    localparam int KC1       = 85627;
    localparam int KC2       = 35468;
    localparam int MUL_SHIFT = 16;

    // Rounding: the horizontal pass adds 4 before the final shift by 3
    localparam int PASS1_BIAS    = 0;
    localparam int PASS2_BIAS    = 4;
    localparam int DESCALE_SHIFT = 3;

    // Width of the optional delivered-block counter
    localparam int BLK_CNT_W = 16;

    // Largest legal reconstructed pixel, at reconstruction-sum width
    localparam logic signed [RECON_W-1:0] RECON_MAX = RECON_W'(255);

    typedef logic [PIX_W-1:0] pixel_t;

    // Signed Q16 multiply: full product followed by an arithmetic shift,
    // so negative values round towards minus infinity.
    function automatic logic signed [PROD_W-1:0] mul_q16(
        input logic signed [PROD_W-1:0] x,
        input logic signed [PROD_W-1:0] k
    );
        logic signed [PROD_W-1:0] prod;
        prod = x * k;
        return prod >>> MUL_SHIFT;
    endfunction

    // Add the descaled residual to a prediction pixel and saturate to 0..255.
    function automatic pixel_t recon_pixel(
        input pixel_t                  pred,
        input logic signed [SUM_W-1:0] resid
    );
        logic signed [SUM_W-1:0]   descaled;
        logic signed [RECON_W-1:0] sum;
        descaled = resid >>> DESCALE_SHIFT;
        sum = $signed({{(RECON_W-PIX_W){1'b0}}, pred})
            + $signed({{(RECON_W-SUM_W){descaled[SUM_W-1]}}, descaled});
        if (sum[RECON_W-1]) begin
            return '0;
        end else if (sum > RECON_MAX) begin
            return '1;
        end else begin
            return sum[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/itransform_butterfly.sv
// itransform_butterfly: one 4-point inverse butterfly, purely combinational.
// Used for both the vertical pass (12-bit in, 14-bit out, no bias) and the
// horizontal pass (14-bit in, 17-bit out, +4 rounding bias on the even part).
module itransform_butterfly
    import itransform_pkg::*;
#(
    parameter int IN_W  = COEFF_W,
    parameter int OUT_W = TMP_W,
    parameter int BIAS  = PASS1_BIAS
) (
    input  logic signed [IN_W-1:0]  in_0,
    input  logic signed [IN_W-1:0]  in_1,
    input  logic signed [IN_W-1:0]  in_2,
    input  logic signed [IN_W-1:0]  in_3,
    output logic signed [OUT_W-1:0] out_0,
    output logic signed [OUT_W-1:0] out_1,
    output logic signed [OUT_W-1:0] out_2,
    output logic signed [OUT_W-1:0] out_3
);

    localparam logic signed [PROD_W-1:0] KC1_S  = PROD_W'(KC1);
    localparam logic signed [PROD_W-1:0] KC2_S  = PROD_W'(KC2);
    localparam logic signed [PROD_W-1:0] BIAS_S = PROD_W'(BIAS);

    logic signed [PROD_W-1:0] x0;
    logic signed [PROD_W-1:0] x1;
    logic signed [PROD_W-1:0] x2;
    logic signed [PROD_W-1:0] x3;
    logic signed [PROD_W-1:0] even_a;
    logic signed [PROD_W-1:0] even_b;
    logic signed [PROD_W-1:0] odd_c;
    logic signed [PROD_W-1:0] odd_d;

    // Widen the inputs once so every product and sum is formed at 32 bits
    // and can never wrap; only the final outputs are narrowed.
    always_comb begin
        x0 = {{(PROD_W-IN_W){in_0[IN_W-1]}}, in_0};
        x1 = {{(PROD_W-IN_W){in_1[IN_W-1]}}, in_1};
        x2 = {{(PROD_W-IN_W){in_2[IN_W-1]}}, in_2};
        x3 = {{(PROD_W-IN_W){in_3[IN_W-1]}}, in_3};

        even_a = x0 + x2 + BIAS_S;
        even_b = x0 - x2 + BIAS_S;
        odd_c  = mul_q16(x1, KC2_S) - mul_q16(x3, KC1_S);
        odd_d  = mul_q16(x1, KC1_S) + mul_q16(x3, KC2_S);

        out_0 = OUT_W'(even_a + odd_d);
        out_1 = OUT_W'(even_b + odd_c);
        out_2 = OUT_W'(even_b - odd_c);
        out_3 = OUT_W'(even_a - odd_d);
    end

endmodule

// File: rtl/itransform.sv
// itransform: 4x4 inverse transform plus prediction add, two-stage pipeline.
// Stage 1 captures the vertical-pass result and the prediction block on
// acceptance; stage 2 runs the horizontal pass, reconstructs and registers
// dst. Both stages use valid/ready backpressure with full throughput.
// Optional feature: define ITRANSFORM_STATS_EN to add the blk_cnt output,
// a wrapping count of blocks delivered on the output handshake.
// The prediction input is named ref_pix because "ref" is a reserved word.
module itransform
    import itransform_pkg::*;
#(
    parameter int BLOCK_SIZE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_ELEMS*COEFF_W-1:0] coeff,
    input  logic [NUM_ELEMS*PIX_W-1:0]   ref_pix,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_ELEMS*PIX_W-1:0]   dst
`ifdef ITRANSFORM_STATS_EN
    ,
    output logic [BLK_CNT_W-1:0]         blk_cnt
`endif
);

    // Handshake and stage occupancy
    logic s1_valid_q;
    logic s1_valid_d;
    logic out_valid_q;
    logic out_valid_d;
    logic s2_advance;
    logic s1_advance;
    logic accept;

    // Vertical-pass results and stage-1 storage
    logic [NUM_ELEMS-1:0][TMP_W-1:0] col_out;
    logic [NUM_ELEMS-1:0][TMP_W-1:0] tmp_q;
    logic [NUM_ELEMS-1:0][TMP_W-1:0] tmp_d;
    logic [NUM_ELEMS-1:0][PIX_W-1:0] ref_q;
    logic [NUM_ELEMS-1:0][PIX_W-1:0] ref_d;

    // Horizontal-pass results, reconstruction and stage-2 storage
    logic [NUM_ELEMS-1:0][SUM_W-1:0] row_out;
    logic [NUM_ELEMS-1:0][PIX_W-1:0] recon;
    logic [NUM_ELEMS-1:0][PIX_W-1:0] dst_q;
    logic [NUM_ELEMS-1:0][PIX_W-1:0] dst_d;

    // Vertical pass: one butterfly per column of the raw coefficients;
    // column c's four results land in tmp[4c .. 4c+3].
    for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_col
        itransform_butterfly #(
            .IN_W  (COEFF_W),
            .OUT_W (TMP_W),
            .BIAS  (PASS1_BIAS)
        ) u_col (
            .in_0  (coeff[COEFF_W*c                +: COEFF_W]),
            .in_1  (coeff[COEFF_W*(BLOCK_SIZE+c)   +: COEFF_W]),
            .in_2  (coeff[COEFF_W*(2*BLOCK_SIZE+c) +: COEFF_W]),
            .in_3  (coeff[COEFF_W*(3*BLOCK_SIZE+c) +: COEFF_W]),
            .out_0 (col_out[BLOCK_SIZE*c+0]),
            .out_1 (col_out[BLOCK_SIZE*c+1]),
            .out_2 (col_out[BLOCK_SIZE*c+2]),
            .out_3 (col_out[BLOCK_SIZE*c+3])
        );
    end

    // Horizontal pass: the stored tmp is column-major, so row r gathers
    // tmp[r], tmp[4+r], tmp[8+r], tmp[12+r]; results are raster order.
    for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
        itransform_butterfly #(
            .IN_W  (TMP_W),
            .OUT_W (SUM_W),
            .BIAS  (PASS2_BIAS)
        ) u_row (
            .in_0  (tmp_q[r]),
            .in_1  (tmp_q[BLOCK_SIZE+r]),
            .in_2  (tmp_q[2*BLOCK_SIZE+r]),
            .in_3  (tmp_q[3*BLOCK_SIZE+r]),
            .out_0 (row_out[BLOCK_SIZE*r+0]),
            .out_1 (row_out[BLOCK_SIZE*r+1]),
            .out_2 (row_out[BLOCK_SIZE*r+2]),
            .out_3 (row_out[BLOCK_SIZE*r+3])
        );
    end

    // Pipeline control: stage 2 moves when its output is empty or taken,
    // stage 1 moves when it is empty or stage 2 moves.
    always_comb begin
        s2_advance = !out_valid_q || out_ready;
        s1_advance = !s1_valid_q || s2_advance;
        accept     = in_valid && s1_advance;
        in_ready   = s1_advance;
    end

    // Stage 1 next state: capture the vertical pass and prediction on accept
    always_comb begin
        s1_valid_d = s1_valid_q;
        tmp_d      = tmp_q;
        ref_d      = ref_q;
        if (s1_advance) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            tmp_d = col_out;
            ref_d = ref_pix;
        end
    end

    // Reconstruct every pixel from the horizontal pass and stored prediction
    always_comb begin
        recon = '0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            recon[k] = recon_pixel(ref_q[k], row_out[k]);
        end
    end

    // Stage 2 next state: take stage 1 when advancing, otherwise hold dst
    always_comb begin
        out_valid_d = out_valid_q;
        dst_d       = dst_q;
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dst_d = recon;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            tmp_q       <= '0;
            ref_q       <= '0;
            dst_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            tmp_q       <= tmp_d;
            ref_q       <= ref_d;
            dst_q       <= dst_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dst       = dst_q;

`ifdef ITRANSFORM_STATS_EN
    logic                 out_fire;
    logic [BLK_CNT_W-1:0] blk_cnt_q;
    logic [BLK_CNT_W-1:0] blk_cnt_d;

    // Count delivered blocks; the counter wraps naturally at 16 bits
    always_comb begin
        out_fire  = out_valid_q && out_ready;
        blk_cnt_d = blk_cnt_q;
        if (out_fire) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
        end
    end

    // Delivered-block counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_itransform.sv
// tb_itransform: self-checking bench for itransform.
// Directed cases cover reset, DC and clipping blocks, stall and reset with
// blocks in flight; a random run checks every block against an integer
// model of the inverse transform. Build with ITRANSFORM_STATS_EN to also
// check blk_cnt.
module tb_itransform;

    localparam int NUM_RANDOM = 10000;
    localparam int FULL_RATE_BLOCKS = 500;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] coeff;
    logic [127:0] ref_pix;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dst;
`ifdef ITRANSFORM_STATS_EN
    logic [15:0]  blk_cnt;
`endif

    int n_checks;
    int n_fails;

    itransform #(
        .BLOCK_SIZE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coeff     (coeff),
        .ref_pix   (ref_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst       (dst)
`ifdef ITRANSFORM_STATS_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q16 multiply with floor rounding, done in 64-bit integers
    function automatic int mul16(input int x, input int k);
        longint p;
        p = longint'(x) * longint'(k);
        return int'(p >>> 16);
    endfunction

    // Reference reconstruction straight from the arithmetic definition
    function automatic logic [127:0] model(input logic [191:0] cf, input logic [127:0] rp);
        int c [16];
        int t [16];
        int v [16];
        int a, b, cc, d, px;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) c[k] = $signed(cf[12*k +: 12]);
        for (int col = 0; col < 4; col++) begin
            a  = c[col] + c[8+col];
            b  = c[col] - c[8+col];
            cc = mul16(c[4+col], 35468) - mul16(c[12+col], 85627);
            d  = mul16(c[4+col], 85627) + mul16(c[12+col], 35468);
            t[4*col+0] = a + d;
            t[4*col+1] = b + cc;
            t[4*col+2] = b - cc;
            t[4*col+3] = a - d;
        end
        for (int row = 0; row < 4; row++) begin
            a  = t[row] + 4 + t[8+row];
            b  = t[row] + 4 - t[8+row];
            cc = mul16(t[4+row], 35468) - mul16(t[12+row], 85627);
            d  = mul16(t[4+row], 85627) + mul16(t[12+row], 35468);
            v[4*row+0] = a + d;
            v[4*row+1] = b + cc;
            v[4*row+2] = b - cc;
            v[4*row+3] = a - d;
        end
        for (int k = 0; k < 16; k++) begin
            px = int'(rp[8*k +: 8]) + (v[k] >>> 3);
            if (px < 0) px = 0;
            if (px > 255) px = 255;
            res[8*k +: 8] = px[7:0];
        end
        return res;
    endfunction

    // Mix of small coefficients (no clipping) and full-range ones
    function automatic logic [191:0] rand_coeff();
        logic [191:0] cf;
        int val;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) val = int'($urandom_range(0, 4095));
            else val = int'($urandom_range(0, 127)) - 64;
            cf[12*k +: 12] = val[11:0];
        end
        return cf;
    endfunction

    function automatic logic [127:0] rand_ref();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Send one block into an empty pipeline with out_ready high and return
    // the delivered dst plus the number of edges from acceptance to out_valid
    task automatic applyStimulus(input logic [191:0] cf, input logic [127:0] rp,
                                 output logic [127:0] dst_obs, output int lat);
        int guard;
        coeff = cf;
        ref_pix = rp;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            if (out_valid) lat = i;
            else begin
                @(posedge clk); #1;
            end
        end
        dst_obs = dst;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        coeff = '0;
        ref_pix = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (dst !== 128'd0) begin
            n_fails++; $display("[TB] FAIL reset_dst: got %h expected 0", dst);
        end
`ifdef ITRANSFORM_STATS_EN
        n_checks++;
        if (blk_cnt !== 16'd0) begin
            n_fails++; $display("[TB] FAIL reset_blk_cnt: got %0d expected 0", blk_cnt);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_zero_block();
        logic [127:0] d;
        int lat;
        applyStimulus('0, {16{8'h80}}, d, lat);
        n_checks++;
        if (d !== {16{8'h80}}) begin
            n_fails++; $display("[TB] FAIL zero_dst: got %h expected %h", d, {16{8'h80}});
        end
        n_checks++;
        if (lat !== 2) begin
            n_fails++; $display("[TB] FAIL zero_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("[TB] FAIL zero_consumed: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_dc_block();
        logic [191:0] cf;
        logic [127:0] d;
        int lat;
        cf = '0;
        cf[11:0] = 12'd8;
        applyStimulus(cf, {16{8'h10}}, d, lat);
        n_checks++;
        if (d !== {16{8'h11}}) begin
            n_fails++; $display("[TB] FAIL dc_dst: got %h expected %h", d, {16{8'h11}});
        end
        n_checks++;
        if (lat !== 2) begin
            n_fails++; $display("[TB] FAIL dc_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_clip();
        logic [191:0] cf;
        logic [127:0] d;
        int lat;
        cf = '0;
        cf[11:0] = 12'h7FF;
        applyStimulus(cf, {16{8'hFF}}, d, lat);
        n_checks++;
        if (d !== {16{8'hFF}}) begin
            n_fails++; $display("[TB] FAIL clip_high: got %h expected %h", d, {16{8'hFF}});
        end
        cf[11:0] = 12'h800;
        applyStimulus(cf, {16{8'h00}}, d, lat);
        n_checks++;
        if (d !== 128'd0) begin
            n_fails++; $display("[TB] FAIL clip_low: got %h expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [191:0] cf [3];
        logic [127:0] rp [3];
        logic [127:0] exp_d [3];
        logic [127:0] got [3];
        logic [127:0] held;
        logic have_held, pre_acc;
        int acc, rcv;
        for (int i = 0; i < 3; i++) begin
            cf[i] = rand_coeff();
            rp[i] = rand_ref();
            exp_d[i] = model(cf[i], rp[i]);
        end
        held = '0;
        have_held = 1'b0;
        acc = 0;
        out_ready = 1'b0;
        coeff = cf[0];
        ref_pix = rp[0];
        in_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            pre_acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (pre_acc) begin
                acc++;
                if (acc < 3) begin
                    coeff = cf[acc];
                    ref_pix = rp[acc];
                end else in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (!have_held) begin
                    held = dst;
                    have_held = 1'b1;
                end else begin
                    n_checks++;
                    if (dst !== held) begin
                        n_fails++; $display("[TB] FAIL b2b_stall_stable: got %h expected %h", dst, held);
                    end
                end
            end
        end
        n_checks++;
        if (acc !== 2) begin
            n_fails++; $display("[TB] FAIL b2b_accepted_while_stalled: got %0d expected 2", acc);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fails++; $display("[TB] FAIL b2b_in_ready_stalled: got %b expected 0", in_ready);
        end
        n_checks++;
        if (held !== exp_d[0]) begin
            n_fails++; $display("[TB] FAIL b2b_held_block: got %h expected %h", held, exp_d[0]);
        end
        out_ready = 1'b1;
        #1;
        rcv = 0;
        for (int cyc = 0; cyc < 20 && rcv < 3; cyc++) begin
            if (out_valid) begin
                got[rcv] = dst;
                rcv++;
            end
            pre_acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (pre_acc) begin
                acc++;
                in_valid = 1'b0;
            end
            #1;
        end
        n_checks++;
        if (rcv !== 3 || acc !== 3) begin
            n_fails++; $display("[TB] FAIL b2b_count: got %0d out / %0d in expected 3 / 3", rcv, acc);
        end
        for (int i = 0; i < rcv; i++) begin
            n_checks++;
            if (got[i] !== exp_d[i]) begin
                n_fails++; $display("[TB] FAIL b2b_order_%0d: got %h expected %h", i, got[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        out_ready = 1'b0;
        coeff = rand_coeff();
        ref_pix = rand_ref();
        in_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        coeff = rand_coeff();
        ref_pix = rand_ref();
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fails++; $display("[TB] FAIL rif_setup_out_valid: got %b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("[TB] FAIL rif_out_valid_cleared: got %b expected 0", out_valid);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fails++; $display("[TB] FAIL rif_stale_block: got %0d blocks expected 0", seen);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++; $display("[TB] FAIL rif_in_ready: got %b expected 1", in_ready);
        end
`ifdef ITRANSFORM_STATS_EN
        n_checks++;
        if (blk_cnt !== 16'd0) begin
            n_fails++; $display("[TB] FAIL rif_blk_cnt: got %0d expected 0", blk_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [127:0] exp_q [$];
        logic [127:0] e, stall_dst;
        logic stall_pending;
        int sent, rcvd, cycles, full_stalls;
        sent = 0;
        rcvd = 0;
        cycles = 0;
        full_stalls = 0;
        stall_pending = 1'b0;
        stall_dst = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        while (rcvd < NUM_RANDOM && cycles < 60000) begin
            if (sent < NUM_RANDOM) begin
                in_valid = (sent < FULL_RATE_BLOCKS) ? 1'b1 : ($urandom_range(0, 3) != 0);
                coeff = rand_coeff();
                ref_pix = rand_ref();
            end else in_valid = 1'b0;
            out_ready = (sent < FULL_RATE_BLOCKS) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (stall_pending) begin
                n_checks++;
                if (out_valid !== 1'b1 || dst !== stall_dst) begin
                    n_fails++; $display("[TB] FAIL rand_stall_hold: got %b/%h expected 1/%h", out_valid, dst, stall_dst);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(coeff, ref_pix));
                sent++;
            end else if (in_valid && sent < FULL_RATE_BLOCKS) begin
                full_stalls++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++; $display("[TB] FAIL rand_unexpected_block: got %h expected none", dst);
                end else begin
                    e = exp_q.pop_front();
                    if (dst !== e) begin
                        n_fails++; $display("[TB] FAIL rand_dst_%0d: got %h expected %h", rcvd, dst, e);
                    end
                end
                rcvd++;
            end
            stall_pending = out_valid && !out_ready;
            stall_dst = dst;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (rcvd !== NUM_RANDOM) begin
            n_fails++; $display("[TB] FAIL rand_block_count: got %0d expected %0d", rcvd, NUM_RANDOM);
        end
        n_checks++;
        if (full_stalls !== 0) begin
            n_fails++; $display("[TB] FAIL rand_full_rate: got %0d stalls expected 0", full_stalls);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fails++; $display("[TB] FAIL rand_leftover: got %0d pending expected 0", exp_q.size());
        end
`ifdef ITRANSFORM_STATS_EN
        n_checks++;
        if (blk_cnt !== 16'(NUM_RANDOM % 65536)) begin
            n_fails++; $display("[TB] FAIL rand_blk_cnt: got %0d expected %0d", blk_cnt, NUM_RANDOM % 65536);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        test_reset();
        test_zero_block();
        test_dc_block();
        test_clip();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
